// File: rtl/ofdm_tx_qam_mapper.sv
// Serial-bit to QPSK/16-QAM Gray mapper feeding the IFFT subcarrier loader.
// Optional per-frame x^7+x^4+1 scrambler: define OFDM_TX_QAM_MAPPER_SCRAMBLE_EN.
module ofdm_tx_qam_mapper #(
    parameter int BITS_PER_SYM   = 4,
    parameter int SYMS_PER_FRAME = 56,
    parameter int IQ_W           = 8,
    parameter int AMP            = 32
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic                   bit_ready,
    output logic signed [IQ_W-1:0] sym_i,
    output logic signed [IQ_W-1:0] sym_q,
    output logic [7:0]             sym_idx,
    output logic                   sym_last,
    output logic                   sym_valid,
    input  logic                   sym_ready
);

    if (BITS_PER_SYM != 2 && BITS_PER_SYM != 4) begin : g_bad_bps
        $error("BITS_PER_SYM must be 2 or 4");
    end
    if (3 * AMP > 2 ** (IQ_W - 1) - 1) begin : g_bad_amp
        $error("3*AMP does not fit in IQ_W signed");
    end

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] OUTPUT  = 1'b1;

    localparam logic signed [IQ_W-1:0] LVL_P1 = IQ_W'(AMP);
    localparam logic signed [IQ_W-1:0] LVL_M1 = IQ_W'(-AMP);
    localparam logic signed [IQ_W-1:0] LVL_P3 = IQ_W'(3 * AMP);
    localparam logic signed [IQ_W-1:0] LVL_M3 = IQ_W'(-3 * AMP);
    localparam logic [2:0]             LAST_BIT = 3'(BITS_PER_SYM - 1);
    localparam logic [7:0]             LAST_IDX = 8'(SYMS_PER_FRAME - 1);

    logic [0:0]              state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [BITS_PER_SYM-1:0] shift_q, shift_d;
    logic                    bit_ready_q, bit_ready_d;
    logic                    sym_valid_q, sym_valid_d;
    logic signed [IQ_W-1:0]  sym_i_q, sym_i_d, sym_q_q, sym_q_d;
    logic [7:0]              sym_idx_q, sym_idx_d;

    logic                    mapped_bit;
    logic                    bit_acc;
    logic                    sym_acc;
    logic [BITS_PER_SYM-1:0] group;
    logic signed [IQ_W-1:0]  map_i, map_q;

    function automatic logic signed [IQ_W-1:0] gray16(input logic [1:0] pair);
        case (pair)
            2'b00:   return LVL_M3;
            2'b01:   return LVL_M1;
            2'b11:   return LVL_P1;
            default: return LVL_P3;
        endcase
    endfunction

    assign bit_acc = bit_valid & bit_ready_q;
    assign sym_acc = sym_valid_q & sym_ready;

`ifdef OFDM_TX_QAM_MAPPER_SCRAMBLE_EN
    logic [6:0] lfsr_q, lfsr_d;
    logic       lfsr_fb;

    assign lfsr_fb    = lfsr_q[6] ^ lfsr_q[3];
    assign mapped_bit = bit_in ^ lfsr_fb;

    // Reseed after the frame's last symbol so every frame sees the same keystream.
    always_comb begin
        lfsr_d = lfsr_q;
        if (bit_acc) begin
            lfsr_d = {lfsr_q[5:0], lfsr_fb};
        end else if (sym_acc && sym_last) begin
            lfsr_d = 7'h7F;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            lfsr_q <= 7'h7F;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign mapped_bit = bit_in;
`endif

    // First bit received ends up as the group MSB.
    assign group = {shift_q[BITS_PER_SYM-2:0], mapped_bit};

    if (BITS_PER_SYM == 4) begin : g_qam16
        assign map_i = gray16(group[3:2]);
        assign map_q = gray16(group[1:0]);
    end else begin : g_qpsk
        assign map_i = group[1] ? LVL_P1 : LVL_M1;
        assign map_q = group[0] ? LVL_P1 : LVL_M1;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        sym_valid_d = sym_valid_q;
        sym_i_d     = sym_i_q;
        sym_q_d     = sym_q_q;
        sym_idx_d   = sym_idx_q;
        case (state_q)
            COLLECT: begin
                if (bit_acc) begin
                    if (cnt_q == LAST_BIT) begin
                        cnt_d       = '0;
                        shift_d     = '0;
                        sym_i_d     = map_i;
                        sym_q_d     = map_q;
                        sym_valid_d = 1'b1;
                        state_d     = OUTPUT;
                    end else begin
                        cnt_d   = cnt_q + 3'd1;
                        shift_d = group;
                    end
                end
            end
            default: begin
                if (sym_acc) begin
                    sym_valid_d = 1'b0;
                    sym_idx_d   = (sym_idx_q == LAST_IDX) ? 8'd0 : sym_idx_q + 8'd1;
                    state_d     = COLLECT;
                end
            end
        endcase
        bit_ready_d = (state_d == COLLECT);
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            shift_q     <= '0;
            bit_ready_q <= 1'b0;
            sym_valid_q <= 1'b0;
            sym_i_q     <= '0;
            sym_q_q     <= '0;
            sym_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            bit_ready_q <= bit_ready_d;
            sym_valid_q <= sym_valid_d;
            sym_i_q     <= sym_i_d;
            sym_q_q     <= sym_q_d;
            sym_idx_q   <= sym_idx_d;
        end
    end

    assign bit_ready = bit_ready_q;
    assign sym_valid = sym_valid_q;
    assign sym_i     = sym_i_q;
    assign sym_q     = sym_q_q;
    assign sym_idx   = sym_idx_q;
    assign sym_last  = sym_valid_q && (sym_idx_q == LAST_IDX);

endmodule

// File: tb/tb_ofdm_tx_qam_mapper.sv
// Randomized bench for ofdm_tx_qam_mapper against a symbol-level reference model.
// Honours OFDM_TX_QAM_MAPPER_SCRAMBLE_EN when defined.
module tb_ofdm_tx_qam_mapper;

    localparam int BPS  = 4;
    localparam int SPF  = 56;
    localparam int IQ_W = 8;
    localparam int AMP  = 32;

    logic                   clk = 1'b0;
    logic                   nreset = 1'b0;
    logic                   bit_in = 1'b0;
    logic                   bit_valid = 1'b0;
    logic                   bit_ready;
    logic signed [IQ_W-1:0] sym_i;
    logic signed [IQ_W-1:0] sym_q;
    logic [7:0]             sym_idx;
    logic                   sym_last;
    logic                   sym_valid;
    logic                   sym_ready = 1'b0;

    ofdm_tx_qam_mapper #(
        .BITS_PER_SYM   (BPS),
        .SYMS_PER_FRAME (SPF),
        .IQ_W           (IQ_W),
        .AMP            (AMP)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .sym_i     (sym_i),
        .sym_q     (sym_q),
        .sym_idx   (sym_idx),
        .sym_last  (sym_last),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int i;
        int q;
        int idx;
        int last;
    } sym_t;

    int   checks = 0;
    int   failures = 0;
    sym_t pend[$];
    int   grp_val = 0;
    int   grp_cnt = 0;
    int   frame_idx = 0;
    int   model_lasts = 0;
    int   dut_lasts = 0;
    logic edge_rn = 1'b0;
    bit   ks[SPF*BPS];

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Gray pair -> natural index -> level (2n-3)*A.
    function automatic int level16(input int pair);
        int n;
        n = pair ^ (pair >> 1);
        return (2 * n - 3) * AMP;
    endfunction

    function automatic sym_t make_sym(input int v, input int idx);
        sym_t s;
        if (BPS == 4) begin
            s.i = level16((v >> 2) & 3);
            s.q = level16(v & 3);
        end else begin
            s.i = (2 * ((v >> 1) & 1) - 1) * AMP;
            s.q = (2 * (v & 1) - 1) * AMP;
        end
        s.idx  = idx;
        s.last = (idx == SPF - 1) ? 1 : 0;
        return s;
    endfunction

    // One cycle: check what the last edge produced, then drive the next edge's inputs.
    task automatic step(input logic v, input logic b, input logic r, input logic rn,
                        output logic taken);
        logic exp_rdy;
        logic exp_vld;
        int   pos;
        @(negedge clk);
        exp_vld = (pend.size() != 0);
        exp_rdy = edge_rn && !exp_vld;
        check("bit_ready", bit_ready, exp_rdy);
        check("sym_valid", sym_valid, exp_vld);
        if (exp_vld) begin
            check("sym_i", sym_i, pend[0].i);
            check("sym_q", sym_q, pend[0].q);
            check("sym_idx", sym_idx, pend[0].idx);
            check("sym_last", sym_last, pend[0].last);
        end else if (!edge_rn) begin
            check("rst_sym_i", sym_i, 0);
            check("rst_sym_q", sym_q, 0);
            check("rst_sym_idx", sym_idx, 0);
            check("rst_sym_last", sym_last, 0);
        end
        bit_valid = v;
        bit_in    = b;
        sym_ready = r;
        nreset    = rn;
        taken     = 1'b0;
        if (!rn) begin
            pend.delete();
            grp_val   = 0;
            grp_cnt   = 0;
            frame_idx = 0;
        end else begin
            if (exp_vld && r) begin
                if (sym_last === 1'b1) dut_lasts++;
                if (pend[0].last != 0) model_lasts++;
                void'(pend.pop_front());
                frame_idx = (frame_idx + 1) % SPF;
            end
            if (v && exp_rdy) begin
                taken   = 1'b1;
                pos     = frame_idx * BPS + grp_cnt;
                grp_val = grp_val * 2 + (int'(b) ^ int'(ks[pos]));
                grp_cnt++;
                if (grp_cnt == BPS) begin
                    pend.push_back(make_sym(grp_val, frame_idx));
                    grp_val = 0;
                    grp_cnt = 0;
                end
            end
        end
        edge_rn = rn;
    endtask

    task automatic do_reset(input int n);
        logic t;
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, t);
        step(1'b0, 1'b0, 1'b0, 1'b1, t);
    endtask

    task automatic idle(input logic r);
        logic t;
        step(1'b0, 1'b0, r, 1'b1, t);
    endtask

    task automatic send_bit(input logic b, input logic r);
        logic t;
        t = 1'b0;
        for (int k = 0; k < 40 && !t; k++) step(1'b1, b, r, 1'b1, t);
        if (!t) check("bit_accept_timeout", 0, 1);
    endtask

    task automatic send_nib(input logic [3:0] n, input logic r);
        for (int k = 3; k >= 0; k--) send_bit(n[k], r);
    endtask

    task automatic expect_now(input string tag, input int ei, input int eq, input int eidx);
        check({tag, "_valid"}, sym_valid, 1);
        check({tag, "_i"}, sym_i, ei);
        check({tag, "_q"}, sym_q, eq);
        check({tag, "_idx"}, sym_idx, eidx);
    endtask

    initial begin
        logic t;
        logic [6:0] s;
        logic       f;
        s = 7'h7F;
        for (int p = 0; p < SPF * BPS; p++) begin
`ifdef OFDM_TX_QAM_MAPPER_SCRAMBLE_EN
            f = s[6] ^ s[3];
            s = {s[5:0], f};
`else
            f = 1'b0;
`endif
            ks[p] = f;
        end

        do_reset(3);

`ifndef OFDM_TX_QAM_MAPPER_SCRAMBLE_EN
        // 1011 -> (+3A, +A); then a long stall with bits offered.
        send_nib(4'b1011, 1'b0);
        idle(1'b0);
        expect_now("t1011", 96, 32, 0);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b0, 1'b1, t);
        idle(1'b1);

        do_reset(2);
        send_nib(4'b0000, 1'b1);
        idle(1'b1);
        expect_now("t0000", -96, -96, 0);
        send_nib(4'b0110, 1'b1);
        idle(1'b1);
        expect_now("t0110", -32, 96, 1);

        // Reset with a half-built group.
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        do_reset(2);
        send_nib(4'b1011, 1'b0);
        idle(1'b0);
        expect_now("t_rst", 96, 32, 0);
        idle(1'b1);
`else
        do_reset(2);
        send_nib(4'b0000, 1'b1);
        idle(1'b1);
        expect_now("scr0", -96, -96, 0);
        send_nib(4'b0000, 1'b1);
        idle(1'b1);
        expect_now("scr1", 32, 96, 1);
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b1);
        do_reset(2);
`endif

        // Random traffic long enough for several frame wraps.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 9) < 8, 1'($urandom), $urandom_range(0, 9) < 7, 1'b1, t);
        end
        for (int c = 0; c < 20; c++) idle(1'b1);
        check("frame_lasts", dut_lasts, model_lasts);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
